// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline control blocks.
package mips_pkg;

  localparam int REG_AW         = 5;
  localparam int MULDIV_LAT_DEF = 4;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    LOAD_STALL  = 2'd1,
    MULDIV_WAIT = 2'd2
  } hz_state_t;

endpackage

// File: rtl/muldiv_busy_cnt.sv
// Tracks an in-flight mult/div op: loads LAT on start, counts down to zero.
// Latency: busy rises the cycle after start and stays high for LAT cycles.
// Backpressure: none; a start while busy simply reloads the count.
module muldiv_busy_cnt
  import mips_pkg::*;
#(
  parameter int LAT = MULDIV_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= 4'(LAT);
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign busy = (cnt != 4'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flush, mult/div HI/LO interlock.
// Latency: all controls are combinational from current inputs and busy state.
// Backpressure: stall holds PC and IF/ID; optional HAZARD_PERF_CNT_EN adds stall counters.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MULDIV_LAT = MULDIV_LAT_DEF,
  parameter int REG_AW     = mips_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_reads_hilo,
  input  logic              id_muldiv,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_branch_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              muldiv_start,
  output logic              muldiv_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]       perf_load_stalls,
  output logic [15:0]       perf_muldiv_stalls
`endif
);

  logic      load_use;
  logic      muldiv_hz;
  logic      stall;
  hz_state_t state;

  // Register 0 is hardwired, so a load targeting it can never create a hazard.
  assign load_use = ex_mem_read && (ex_rt != REG_AW'(REG_ZERO)) &&
                    ((id_uses_rs && (id_rs == ex_rt)) ||
                     (id_uses_rt && (id_rt == ex_rt)));

  assign muldiv_hz = muldiv_busy && (id_reads_hilo || id_muldiv);
  assign stall     = load_use || muldiv_hz;

  assign pc_write     = !stall;
  assign ifid_write   = !stall;
  assign idex_bubble  = stall;
  // A taken branch with pending operands waits; it re-resolves next cycle.
  assign ifid_flush   = id_branch_taken && !stall;
  assign muldiv_start = id_muldiv && !stall;

  muldiv_busy_cnt #(
    .LAT(MULDIV_LAT)
  ) u_busy_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .start(muldiv_start),
    .busy (muldiv_busy)
  );

  // Debug-only state; no output is derived from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (load_use)       state <= LOAD_STALL;
          else if (muldiv_hz) state <= MULDIV_WAIT;
        end
        LOAD_STALL:  state <= RUN;
        MULDIV_WAIT: if (!muldiv_busy) state <= RUN;
        default:     state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Coincident stalls are attributed to the load-use counter only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_load_stalls   <= '0;
      perf_muldiv_stalls <= '0;
    end else begin
      if (load_use && (perf_load_stalls != 16'hFFFF))
        perf_load_stalls <= perf_load_stalls + 16'd1;
      if (muldiv_hz && !load_use && (perf_muldiv_stalls != 16'hFFFF))
        perf_muldiv_stalls <= perf_muldiv_stalls + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed checks of hazard_ctrl against a cycle-indexed reference model.
module tb_hazard_ctrl;

  localparam int LAT = 4;
  localparam int AW  = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] id_rs, id_rt, ex_rt;
  logic          id_uses_rs, id_uses_rt, id_reads_hilo, id_muldiv;
  logic          ex_mem_read, id_branch_taken;
  logic          pc_write, ifid_write, ifid_flush, idex_bubble;
  logic          muldiv_start, muldiv_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0]   perf_load_stalls, perf_muldiv_stalls;
`endif

  hazard_ctrl #(.MULDIV_LAT(LAT), .REG_AW(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .id_reads_hilo  (id_reads_hilo),
    .id_muldiv      (id_muldiv),
    .ex_mem_read    (ex_mem_read),
    .ex_rt          (ex_rt),
    .id_branch_taken(id_branch_taken),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .ifid_flush     (ifid_flush),
    .idex_bubble    (idex_bubble),
    .muldiv_start   (muldiv_start),
    .muldiv_busy    (muldiv_busy)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_load_stalls  (perf_load_stalls),
    .perf_muldiv_stalls(perf_muldiv_stalls)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: HI/LO becomes readable at absolute cycle ready_cyc.
  int cyc       = 0;
  int ready_cyc = 0;
  int m_load    = 0;
  int m_mdiv    = 0;
  bit exp_start;
  bit s_pc, s_flush, s_start, s_busy;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_idle();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rs = 0; id_uses_rt = 0; id_reads_hilo = 0; id_muldiv = 0;
    ex_mem_read = 0; id_branch_taken = 0;
  endtask

  task automatic check_model();
    bit busy, lu, mh, st;
    busy = (cyc < ready_cyc);
    lu   = ex_mem_read && (ex_rt != 0) &&
           ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
    mh   = busy && (id_reads_hilo || id_muldiv);
    st   = lu || mh;
    exp_start = id_muldiv && !st;
    check_val("pc_write",     pc_write,     !st);
    check_val("ifid_write",   ifid_write,   !st);
    check_val("idex_bubble",  idex_bubble,  st);
    check_val("ifid_flush",   ifid_flush,   id_branch_taken && !st);
    check_val("muldiv_start", muldiv_start, exp_start);
    check_val("muldiv_busy",  muldiv_busy,  busy);
`ifdef HAZARD_PERF_CNT_EN
    check_val("perf_load",   perf_load_stalls,   m_load);
    check_val("perf_muldiv", perf_muldiv_stalls, m_mdiv);
    if (lu && m_load < 65535) m_load++;
    if (mh && !lu && m_mdiv < 65535) m_mdiv++;
`else
    if (lu) m_load++;
    if (mh && !lu) m_mdiv++;
`endif
    s_pc = pc_write; s_flush = ifid_flush; s_start = muldiv_start; s_busy = muldiv_busy;
  endtask

  // Inputs are already applied at posedge+1; sample mid-cycle, then advance.
  task automatic tick();
    #3;
    check_model();
    @(posedge clk);
    if (exp_start) ready_cyc = cyc + LAT + 1;
    cyc++;
    #1;
  endtask

  initial begin
    int n;
    set_idle();
    rst_n = 1'b0;
    #2;
    check_val("rst_pc_write",   pc_write,     1);
    check_val("rst_ifid_write", ifid_write,   1);
    check_val("rst_flush",      ifid_flush,   0);
    check_val("rst_bubble",     idex_bubble,  0);
    check_val("rst_start",      muldiv_start, 0);
    check_val("rst_busy",       muldiv_busy,  0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load-use on rs, then clear.
    ex_mem_read = 1; ex_rt = 5; id_rs = 5; id_uses_rs = 1;
    tick();
    check_val("lu_stall", s_pc, 0);
    set_idle();
    tick();
    check_val("lu_release", s_pc, 1);

    // Same load targeting r0 never stalls.
    ex_mem_read = 1; ex_rt = 0; id_rs = 0; id_uses_rs = 1;
    tick();
    check_val("r0_no_stall", s_pc, 1);

    // Stall beats a taken branch; flush once operands are ready.
    ex_mem_read = 1; ex_rt = 7; id_rt = 7; id_uses_rt = 1; id_branch_taken = 1;
    tick();
    check_val("br_held", s_flush, 0);
    ex_mem_read = 0;
    tick();
    check_val("br_flush", s_flush, 1);
    set_idle();

    // MULT then MFHI: MFHI is held while busy is high.
    id_muldiv = 1;
    tick();
    check_val("mult_start", s_start, 1);
    id_muldiv = 0; id_reads_hilo = 1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_pc) break;
      n++;
    end
    check_val("mfhi_stall_len", n, LAT);
    set_idle();

    // Back-to-back MULT: the second waits for the first, then restarts busy.
    id_muldiv = 1;
    tick();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_start) break;
      n++;
    end
    check_val("b2b_wait", n, LAT);
    set_idle();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!s_busy) break;
      n++;
    end
    check_val("b2b_busy_len", n, LAT);

    // Reset asserted while MFHI waits on a running MULT.
    id_muldiv = 1;
    tick();
    id_muldiv = 0; id_reads_hilo = 1;
    tick();
    check_val("pre_rst_stall", s_pc, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_busy",     muldiv_busy, 0);
    check_val("arst_pc_write", pc_write,    1);
    check_val("arst_bubble",   idex_bubble, 0);
`ifdef HAZARD_PERF_CNT_EN
    check_val("arst_perf_load",   perf_load_stalls,   0);
    check_val("arst_perf_muldiv", perf_muldiv_stalls, 0);
`endif
    ready_cyc = 0; m_load = 0; m_mdiv = 0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    tick();
    check_val("post_rst_mfhi", s_pc, 1);
    set_idle();

    // Randomized traffic biased toward register collisions and mult/div use.
    for (int i = 0; i < 600; i++) begin
      id_rs           = AW'($urandom_range(0, 3));
      id_rt           = AW'($urandom_range(0, 3));
      ex_rt           = AW'($urandom_range(0, 3));
      id_uses_rs      = ($urandom_range(0, 1) == 1);
      id_uses_rt      = ($urandom_range(0, 1) == 1);
      ex_mem_read     = ($urandom_range(0, 2) == 0);
      id_muldiv       = ($urandom_range(0, 7) == 0);
      id_reads_hilo   = !id_muldiv && ($urandom_range(0, 4) == 0);
      id_branch_taken = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
